// File: rtl/led_sched_pkg.sv
// Shared types, constants and pattern decode for the LED pattern scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BLINK = 2'd1,
        PAT_WALK  = 2'd2,
        PAT_COUNT = 2'd3
    } pat_t;

    localparam logic [3:0] LED_OFF = 4'hF;

    // Active-low LED image for a pattern code at a given step.
    function automatic logic [3:0] pat_decode(input pat_t code, input logic [3:0] step);
        logic [3:0] img;
        case (code)
            PAT_SOLID: img = 4'h0;
            PAT_BLINK: img = step[0] ? LED_OFF : 4'h0;
            PAT_WALK:  img = ~(4'b0001 << step[1:0]);
            default:   img = ~step;
        endcase
        return img;
    endfunction

endpackage

// File: rtl/led_pattern_sched_if.sv
// Requester/LED bundle of the LED pattern scheduler.
interface led_pattern_sched_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] pat;
    logic [3:0]         led_n;
    logic [N_REQ-1:0]   gnt;
    logic               tick;

    modport master (output req, output pat, input led_n, input gnt, input tick);
    modport slave  (input req, input pat, output led_n, output gnt, output tick);
endinterface

// File: rtl/led_tick_gen.sv
// Tick divider: one-cycle registered pulse every TICK_DIV clocks.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic nRst,
    output logic tick
);
    localparam logic [31:0] RELOAD = 32'(TICK_DIV - 1);

    logic [31:0] cnt;

    // Down-counter; pulse and reload when it reaches zero.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else if (cnt == 32'd0) begin
            cnt  <= RELOAD;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - 32'd1;
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: arbitrates 4 board LEDs among requesters with
// minimum dwell and an all-off gap between owners.
// Build option: LED_SCHED_RR_EN selects round-robin instead of fixed priority.
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned DWELL     = 4,
    parameter int unsigned GAP_TICKS = 1
) (
    input logic               clk,
    input logic               nRst,
    led_pattern_sched_if.slave bus
);
    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DWELL_W = $clog2(DWELL + 1);
    localparam int unsigned GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    logic               tick;
    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [3:0]         led_q, led_d;
    logic [3:0]         step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    pat_t               code_q, code_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   idx;
    pat_t               win_code;
    logic               owner_req;
    logic               other_req;
    logic               do_grant;
    logic               do_gap;
    logic [3:0]         step_inc;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .nRst (nRst),
        .tick (tick)
    );

    assign bus.tick  = tick;
    assign bus.gnt   = gnt_q;
    assign bus.led_n = led_q;

    // Arbiter: first set request from the search start.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_code  = PAT_SOLID;
        idx       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef LED_SCHED_RR_EN
            idx = IDX_W'((32'(ptr_q) + i) % N_REQ);
`else
            idx = IDX_W'(i);
`endif
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
                win_code  = pat_t'(bus.pat[{idx, 1'b0} +: 2]);
            end
        end
    end

    assign owner_req = |(bus.req & gnt_q);
    assign other_req = |(bus.req & ~gnt_q);
    assign step_inc  = step_q + 4'd1;

    // Next-state and output decode; everything advances only on tick.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        led_d    = led_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        gap_d    = gap_q;
        code_d   = code_q;
        ptr_d    = ptr_q;
        do_grant = 1'b0;
        do_gap   = 1'b0;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    do_grant = win_found;
                end
                ST_SHOW: begin
                    if (!owner_req) begin
                        do_gap = 1'b1;
                    end else if (dwell_q == DWELL_W'(1)) begin
                        if (other_req) begin
                            do_gap = 1'b1;
                        end else begin
                            dwell_d = DWELL_W'(DWELL);
                            step_d  = step_inc;
                            led_d   = pat_decode(code_q, step_inc);
                        end
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                        step_d  = step_inc;
                        led_d   = pat_decode(code_q, step_inc);
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        if (win_found) begin
                            do_grant = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    led_d   = LED_OFF;
                end
            endcase
        end

        if (do_grant) begin
            state_d = ST_SHOW;
            gnt_d   = N_REQ'(1) << win_idx;
            code_d  = win_code;
            step_d  = 4'd0;
            dwell_d = DWELL_W'(DWELL);
            led_d   = pat_decode(win_code, 4'd0);
            ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end

        if (do_gap) begin
            state_d = ST_GAP;
            gnt_d   = '0;
            led_d   = LED_OFF;
            gap_d   = GAP_W'(GAP_TICKS - 1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            led_q   <= LED_OFF;
            step_q  <= 4'd0;
            dwell_q <= '0;
            gap_q   <= '0;
            code_q  <= PAT_SOLID;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched (TICK_DIV=4, DWELL=2, GAP_TICKS=1).
module tb_led_pattern_sched;
    logic clk;
    logic nRst;
    int   checks;
    int   errors;

    led_pattern_sched_if #(.N_REQ(4)) bus ();

    led_pattern_sched #(
        .N_REQ     (4),
        .TICK_DIV  (4),
        .DWELL     (2),
        .GAP_TICKS (1)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two cycles, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        nRst    = 1'b0;
        bus.req = 4'b0000;
        bus.pat = 8'h00;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
    endtask

    // Advance to the falling edge where the effect of the next tick is visible.
    task automatic next_tick();
        int n;
        @(negedge clk);
        n = 1;
        while (bus.tick !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no tick within %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.led_n !== 4'hF || bus.gnt !== 4'b0000 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: led_n=%h gnt=%b tick=%b expected F 0000 0", bus.led_n, bus.gnt, bus.tick);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (k == 4)) begin
                errors++;
                $display("FAIL first_tick: edge %0d tick=%b expected %b", k, bus.tick, (k == 4));
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_led [6] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
        do_reset();
        bus.req = 4'b0100;
        bus.pat = 8'b00_11_00_00;
        for (int k = 0; k < 6; k++) begin
            next_tick();
            checks++;
            if (bus.gnt !== 4'b0100 || bus.led_n !== exp_led[k]) begin
                errors++;
                $display("FAIL single_count: tick %0d gnt=%b led_n=%h expected 0100 %h", k, bus.gnt, bus.led_n, exp_led[k]);
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt2;
`ifdef LED_SCHED_RR_EN
        exp_gnt2 = 4'b1000;
`else
        exp_gnt2 = 4'b0010;
`endif
        do_reset();
        bus.req = 4'b1010;
        bus.pat = 8'h00;
        for (int k = 0; k < 2; k++) begin
            next_tick();
            checks++;
            if (bus.gnt !== 4'b0010 || bus.led_n !== 4'h0) begin
                errors++;
                $display("FAIL contention_first: tick %0d gnt=%b led_n=%h expected 0010 0", k, bus.gnt, bus.led_n);
            end
        end
        next_tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.led_n !== 4'hF) begin
            errors++;
            $display("FAIL contention_gap: gnt=%b led_n=%h expected 0000 F", bus.gnt, bus.led_n);
        end
        next_tick();
        checks++;
        if (bus.gnt !== exp_gnt2 || bus.led_n !== 4'h0) begin
            errors++;
            $display("FAIL contention_regrant: gnt=%b led_n=%h expected %b 0", bus.gnt, bus.led_n, exp_gnt2);
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus.req = 4'b0001;
        bus.pat = 8'h01;
        next_tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.led_n !== 4'h0) begin
            errors++;
            $display("FAIL drop_grant: gnt=%b led_n=%h expected 0001 0", bus.gnt, bus.led_n);
        end
        @(negedge clk);
        bus.req = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            next_tick();
            checks++;
            if (bus.gnt !== 4'b0000 || bus.led_n !== 4'hF) begin
                errors++;
                $display("FAIL drop_release: tick %0d gnt=%b led_n=%h expected 0000 F", k, bus.gnt, bus.led_n);
            end
        end
        bus.req = 4'b0001;
        next_tick();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL drop_idle_regrant: gnt=%b expected 0001", bus.gnt);
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_led [6] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
        do_reset();
        bus.req = 4'b0001;
        bus.pat = 8'h01;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) bus.pat = 8'h02;
            next_tick();
            checks++;
            if (bus.led_n !== exp_led[k]) begin
                errors++;
                $display("FAIL blink: tick %0d led_n=%h expected %h", k, bus.led_n, exp_led[k]);
            end
        end
    endtask

    task automatic test_walk();
        logic [3:0] exp_led [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        do_reset();
        bus.req = 4'b0001;
        bus.pat = 8'h02;
        for (int k = 0; k < 5; k++) begin
            next_tick();
            checks++;
            if (bus.led_n !== exp_led[k]) begin
                errors++;
                $display("FAIL walk: tick %0d led_n=%h expected %h", k, bus.led_n, exp_led[k]);
            end
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        bus.req = 4'b1000;
        bus.pat = 8'h00;
        next_tick();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL preempt_grant: gnt=%b expected 1000", bus.gnt);
        end
        bus.req = 4'b1001;
        next_tick();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.led_n !== 4'h0) begin
            errors++;
            $display("FAIL preempt_hold: gnt=%b led_n=%h expected 1000 0", bus.gnt, bus.led_n);
        end
        next_tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.led_n !== 4'hF) begin
            errors++;
            $display("FAIL preempt_gap: gnt=%b led_n=%h expected 0000 F", bus.gnt, bus.led_n);
        end
        next_tick();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL preempt_winner: gnt=%b expected 0001", bus.gnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0001;
        bus.pat = 8'h00;
        next_tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.led_n !== 4'h0) begin
            errors++;
            $display("FAIL midreset_pre: gnt=%b led_n=%h expected 0001 0", bus.gnt, bus.led_n);
        end
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.led_n !== 4'hF || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: gnt=%b led_n=%h tick=%b expected 0000 F 0", bus.gnt, bus.led_n, bus.tick);
        end
        @(negedge clk);
        nRst = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nRst    = 1'b0;
        bus.req = 4'b0000;
        bus.pat = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_drop();
        test_blink();
        test_walk();
        test_no_preempt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
